// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
package piso_pkg;

   localparam int unsigned DW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SHIFT = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Handshake, strobe and serial-line bundle between a word source and the transmitter.
interface piso_tx_ctrl_if
   import piso_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
);

   logic          tick;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          i_ready;
   logic          o_ser;
   logic          o_busy;
   logic          o_done;

   modport master (
      output tick, i_valid, i_data,
      input  i_ready, o_ser, o_busy, o_done
   );

   modport slave (
      input  tick, i_valid, i_data,
      output i_ready, o_ser, o_busy, o_done
   );

endinterface

// File: rtl/piso_tx_ctrl_bit_cntr.sv
// Data-bit counter: counts 0..DW-1 and flags the last bit of the word.
module bit_cntr
   import piso_pkg::*;
#(
   parameter  int unsigned DW = DW_DEF,
   localparam int unsigned CW = $clog2(DW)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc_c
);

   logic [CW-1:0] cnt;

   // Clear wins over increment; holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Terminal count: the bit now on the line is the word's MSB.
   assign tc_c = (cnt == CW'(DW - 1));

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serializes a DW-bit word as start bit, DW data bits (LSB first), stop bit.
module piso_tx_ctrl
   import piso_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   piso_tx_ctrl_if.slave  bus
);

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] sreg;
   logic [DW-1:0] sreg_nxt;
   logic          ser_q;
   logic          ser_nxt;
   logic          done_q;
   logic          done_nxt;
   logic          cnt_clr;
   logic          cnt_inc;
   logic          last_bit_c;

   bit_cntr #(.DW(DW)) u_bit_cntr (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .tc_c (last_bit_c)
   );

   // State, shift register and registered line outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         sreg   <= '0;
         ser_q  <= 1'b1;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         sreg   <= sreg_nxt;
         ser_q  <= ser_nxt;
         done_q <= done_nxt;
      end
   end

   // Next state; the line level is computed for the state being entered.
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      ser_nxt   = ser_q;
      done_nxt  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            ser_nxt = 1'b1;
            if (bus.i_valid) begin
               state_nxt = START;
               sreg_nxt  = bus.i_data;
               cnt_clr   = 1'b1;
               ser_nxt   = 1'b0;
            end
         end
         START: begin
            if (bus.tick) begin
               state_nxt = SHIFT;
               ser_nxt   = sreg[0];
            end
         end
         SHIFT: begin
            if (bus.tick) begin
               if (last_bit_c) begin
                  state_nxt = STOP;
                  ser_nxt   = 1'b1;
               end else begin
                  sreg_nxt = sreg >> 1;
                  ser_nxt  = sreg[1];
                  cnt_inc  = 1'b1;
               end
            end
         end
         STOP: begin
            if (bus.tick) begin
               state_nxt = IDLE;
               ser_nxt   = 1'b1;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            ser_nxt   = 1'b1;
         end
      endcase
   end

   // Handshake and busy decode straight from state so reset clears them at once.
   assign bus.i_ready = (state == IDLE);
   assign bus.o_busy  = (state != IDLE);
   assign bus.o_ser   = ser_q;
   assign bus.o_done  = done_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Self-checking bench: frames are compared against start/data/stop bit lists built from each word.
module tb_piso_tx_ctrl;

   localparam int unsigned DW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   piso_tx_ctrl_if #(.DW(DW)) bus ();

   piso_tx_ctrl #(.DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected line levels, one per tick period: start 0, data LSB first, stop 1.
   function automatic logic [DW+1:0] frame_of(input logic [DW-1:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   // Present a word at a falling edge; it is taken on the following rising edge.
   task automatic transfer(input logic [DW-1:0] d, input logic t, output logic rdy);
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      bus.tick    = t;
      rdy         = bus.i_ready;
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.tick    = 1'b0;
   endtask

   // Drive DW+2 tick periods from START and record what the line showed in each.
   task automatic run_frame(input int period, input int mid_idx, input logic [DW-1:0] mid_data,
                            output logic [DW+1:0] bits, output int busy_cnt, output int done_early,
                            output int ready_seen, output logic done_end, output logic busy_end);
      bits       = '0;
      busy_cnt   = 0;
      done_early = 0;
      ready_seen = 0;
      for (int k = 0; k < int'(DW) + 2; k++) begin
         if (k == mid_idx) begin
            bus.i_valid = 1'b1;
            bus.i_data  = mid_data;
         end
         for (int w = 0; w < period - 1; w++) begin
            @(negedge clk);
            done_early += int'(bus.o_done);
            ready_seen += int'(bus.i_ready);
         end
         bits[k]     = bus.o_ser;
         busy_cnt   += int'(bus.o_busy);
         done_early += int'(bus.o_done);
         ready_seen += int'(bus.i_ready);
         bus.tick = 1'b1;
         @(negedge clk);
         bus.tick = 1'b0;
      end
      done_end = bus.o_done;
      busy_end = bus.o_busy;
   endtask

   task automatic test_reset();
      bus.tick    = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      rst         = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.o_ser, bus.o_busy, bus.o_done, bus.i_ready} !== 4'b1001) begin
         errors++;
         $display("FAIL reset ser/busy/done/ready got %b want 1001",
                  {bus.o_ser, bus.o_busy, bus.o_done, bus.i_ready});
      end
      rst = 1'b1;
   endtask

   task automatic test_frame_1011();
      logic [DW+1:0] bits;
      int busy_cnt, done_early, ready_seen;
      logic done_end, busy_end, rdy;
      transfer(4'b1011, 1'b0, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL f1011_ready got %b want 1", rdy); end
      run_frame(4, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== 6'b110110) begin errors++; $display("FAIL f1011_bits got %b want 110110", bits); end
      checks++;
      if (busy_cnt !== 6 || busy_end !== 1'b0) begin
         errors++; $display("FAIL f1011_busy got %0d/%b want 6/0", busy_cnt, busy_end);
      end
      checks++;
      if (done_early !== 0 || done_end !== 1'b1) begin
         errors++; $display("FAIL f1011_done got early=%0d end=%b want 0/1", done_early, done_end);
      end
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0) begin errors++; $display("FAIL f1011_done_pulse got %b want 0", bus.o_done); end
   endtask

   task automatic test_random();
      logic [DW+1:0] bits;
      logic [DW-1:0] d;
      int busy_cnt, done_early, ready_seen, p, gap;
      logic done_end, busy_end, rdy;
      for (int n = 0; n < 8; n++) begin
         d = DW'($urandom);
         p = $urandom_range(1, 5);
         transfer(d, 1'($urandom), rdy);
         checks++;
         if (rdy !== 1'b1) begin errors++; $display("FAIL rand%0d_ready got %b want 1", n, rdy); end
         run_frame(p, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
         checks++;
         if (bits !== frame_of(d)) begin
            errors++; $display("FAIL rand%0d_bits d=%h p=%0d got %b want %b", n, d, p, bits, frame_of(d));
         end
         checks++;
         if (busy_cnt !== int'(DW) + 2 || done_early !== 0 || done_end !== 1'b1 || busy_end !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_flags got busy=%0d early=%0d done=%b busyend=%b want %0d/0/1/0",
                     n, busy_cnt, done_early, done_end, busy_end, DW + 2);
         end
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            bus.tick = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.o_ser, bus.o_busy, bus.o_done} !== 3'b100) begin
               errors++; $display("FAIL rand%0d_idle got %b want 100", n, {bus.o_ser, bus.o_busy, bus.o_done});
            end
         end
         bus.tick = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [DW+1:0] bits;
      int busy_cnt, done_early, ready_seen;
      logic done_end, busy_end;
      bus.i_valid = 1'b1;
      bus.i_data  = 4'hA;
      @(negedge clk);
      run_frame(3, 0, 4'h5, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== 6'b110100) begin errors++; $display("FAIL b2b_first_bits got %b want 110100", bits); end
      checks++;
      if (ready_seen !== 0) begin errors++; $display("FAIL b2b_holdoff got %0d want 0", ready_seen); end
      checks++;
      if (done_end !== 1'b1 || bus.i_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_done_ready got %b%b want 11", done_end, bus.i_ready);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_ser !== 1'b0) begin
         errors++; $display("FAIL b2b_restart got busy=%b ser=%b want 1/0", bus.o_busy, bus.o_ser);
      end
      run_frame(3, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== 6'b101010 || done_end !== 1'b1) begin
         errors++; $display("FAIL b2b_second got %b done=%b want 101010 done=1", bits, done_end);
      end
      @(negedge clk);
   endtask

   task automatic test_held_off();
      logic [DW+1:0] bits;
      int busy_cnt, done_early, ready_seen;
      logic done_end, busy_end, rdy;
      transfer(4'h6, 1'b0, rdy);
      run_frame(4, 2, 4'hF, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== frame_of(4'h6) || ready_seen !== 0) begin
         errors++; $display("FAIL holdoff_first got %b ready=%0d want %b ready=0", bits, ready_seen, frame_of(4'h6));
      end
      checks++;
      if (done_end !== 1'b1 || bus.i_ready !== 1'b1) begin
         errors++; $display("FAIL holdoff_accept got %b%b want 11", done_end, bus.i_ready);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL holdoff_taken got %b want 1", bus.o_busy); end
      run_frame(2, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== frame_of(4'hF)) begin errors++; $display("FAIL holdoff_second got %b want %b", bits, frame_of(4'hF)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [DW+1:0] bits;
      int busy_cnt, done_early, ready_seen;
      logic done_end, busy_end, rdy;
      transfer(4'b0011, 1'b0, rdy);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.tick = 1'b1;
         @(negedge clk);
         bus.tick = 1'b0;
      end
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_ser !== 1'b0) begin
         errors++; $display("FAIL rstmid_bit2 got busy=%b ser=%b want 1/0", bus.o_busy, bus.o_ser);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.o_ser, bus.o_busy, bus.o_done, bus.i_ready} !== 4'b1001) begin
         errors++; $display("FAIL rstmid_async got %b want 1001", {bus.o_ser, bus.o_busy, bus.o_done, bus.i_ready});
      end
      @(negedge clk);
      rst = 1'b1;
      transfer(4'h3, 1'b0, rdy);
      checks++;
      if (rdy !== 1'b1 || bus.o_busy !== 1'b1) begin
         errors++; $display("FAIL rstmid_first_xfer got ready=%b busy=%b want 1/1", rdy, bus.o_busy);
      end
      run_frame(3, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== frame_of(4'h3) || done_end !== 1'b1) begin
         errors++; $display("FAIL rstmid_frame got %b done=%b want %b done=1", bits, done_end, frame_of(4'h3));
      end
      @(negedge clk);
   endtask

   task automatic test_data_change();
      logic [DW+1:0] bits;
      int busy_cnt, done_early, ready_seen;
      logic done_end, busy_end, rdy;
      transfer(4'h9, 1'b1, rdy);
      bus.i_data = 4'h6;
      checks++;
      if (bus.o_ser !== 1'b0 || bus.o_busy !== 1'b1) begin
         errors++; $display("FAIL chg_start got ser=%b busy=%b want 0/1", bus.o_ser, bus.o_busy);
      end
      run_frame(4, -1, '0, bits, busy_cnt, done_early, ready_seen, done_end, busy_end);
      checks++;
      if (bits !== frame_of(4'h9) || done_end !== 1'b1) begin
         errors++; $display("FAIL chg_frame got %b done=%b want %b done=1", bits, done_end, frame_of(4'h9));
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_frame_1011();
      test_random();
      test_back_to_back();
      test_held_off();
      test_reset_mid();
      test_data_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
